config_stream_tx: RTL and testbench

CONFIG_STREAM_TX -- requirements
Module: config_stream_tx

---
 rtl/config_stream_pkg.sv | 21 ++
 rtl/config_word_slot.sv | 43 ++++
 rtl/config_stream_tx.sv | 134 +++++++++++++
 tb/tb_config_stream_tx.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/config_stream_pkg.sv
// Shared constants, state encoding and the desync-word helper used by the
// configuration stream transmitter.
package config_stream_pkg;

    localparam logic [31:0] SYNC_WORD = 32'hFAB0_FAB1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SYNCED = 2'd1,
        ST_DATA   = 2'd2
    } stream_state_t;

    // The desync word is all zeros except the header's desync flag bit.
    function automatic logic [31:0] desync_word(input int unsigned flag);
        logic [31:0] w;
        w = '0;
        w[flag[4:0]] = 1'b1;
        return w;
    endfunction

endpackage

// File: rtl/config_word_slot.sv
// Single-entry output register: holds a word (and its last-of-frame tag)
// until the downstream port accepts it.
module config_word_slot (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        load,
    input  logic [31:0] load_data,
    input  logic        load_last,
    input  logic        OutReady,
    output logic [31:0] WriteData,
    output logic        WriteStrobe,
    output logic        slot_free,
    output logic        FrameDone
);

    logic [31:0] data_reg;
    logic        strobe_reg;
    logic        last_reg;

    assign slot_free   = !strobe_reg || OutReady;
    assign WriteData   = data_reg;
    assign WriteStrobe = strobe_reg;
    assign FrameDone   = strobe_reg && OutReady && last_reg;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            data_reg   <= '0;
            strobe_reg <= 1'b0;
            last_reg   <= 1'b0;
        end else if (slot_free) begin
            if (load) begin
                data_reg   <= load_data;
                strobe_reg <= 1'b1;
                last_reg   <= load_last;
            end else begin
                // Data is left as-is; only the valid and tag are cleared.
                strobe_reg <= 1'b0;
                last_reg   <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/config_stream_tx.sv
// Frame sequencer: emits the sync word once per session, then a header and
// NumberOfRows data words per frame, and a desync word to close the session.
import config_stream_pkg::*;

module config_stream_tx #(
    parameter int NumberOfRows    = 16,
    parameter int FrameBitsPerRow = 32,
    parameter int desync_flag     = 20
) (
    input  logic                       CLK,
    input  logic                       Reset,
    input  logic                       FrameValid,
    input  logic [FrameBitsPerRow-1:0] FrameAddress,
    output logic                       FrameReady,
    input  logic                       DataValid,
    input  logic [31:0]                DataWord,
    output logic                       DataReady,
    input  logic                       EndSession,
    output logic [31:0]                WriteData,
    output logic                       WriteStrobe,
    input  logic                       OutReady,
    output logic                       Synced,
    output logic                       FrameDone
);

    localparam int RowBits = $clog2(NumberOfRows + 1);
    localparam logic [RowBits-1:0] RowsInit = RowBits'(NumberOfRows);
    localparam logic [RowBits-1:0] RowOne   = RowBits'(1);

    stream_state_t      state_reg;
    logic [RowBits-1:0] row_count_reg;

    logic        slot_free;
    logic        load;
    logic [31:0] load_data;
    logic        load_last;
    logic [31:0] header_word;

    // Header is the frame address fitted to 32 bits with the desync bit
    // cleared, so a header can never be mistaken for a desync command.
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_header
            if (gi == desync_flag || gi >= FrameBitsPerRow) begin : g_zero
                assign header_word[gi] = 1'b0;
            end else begin : g_pass
                assign header_word[gi] = FrameAddress[gi];
            end
        end
    endgenerate

    always_comb begin
        load       = 1'b0;
        load_data  = '0;
        load_last  = 1'b0;
        FrameReady = 1'b0;
        DataReady  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (FrameValid && slot_free) begin
                    load      = 1'b1;
                    load_data = SYNC_WORD;
                end
            end
            ST_SYNCED: begin
                if (FrameValid && slot_free) begin
                    load       = 1'b1;
                    load_data  = header_word;
                    FrameReady = 1'b1;
                end else if (EndSession && slot_free) begin
                    load      = 1'b1;
                    load_data = desync_word(desync_flag);
                end
            end
            ST_DATA: begin
                if (DataValid && slot_free) begin
                    load      = 1'b1;
                    load_data = DataWord;
                    load_last = (row_count_reg == RowOne);
                    DataReady = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_reg     <= ST_IDLE;
            row_count_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (FrameValid && slot_free)
                        state_reg <= ST_SYNCED;
                end
                ST_SYNCED: begin
                    if (FrameValid && slot_free) begin
                        state_reg     <= ST_DATA;
                        row_count_reg <= RowsInit;
                    end else if (EndSession && slot_free) begin
                        state_reg <= ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (DataValid && slot_free) begin
                        if (row_count_reg == RowOne) begin
                            state_reg     <= ST_SYNCED;
                            row_count_reg <= '0;
                        end else begin
                            row_count_reg <= row_count_reg - RowOne;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign Synced = (state_reg != ST_IDLE);

    config_word_slot u_slot (
        .CLK         (CLK),
        .Reset       (Reset),
        .load        (load),
        .load_data   (load_data),
        .load_last   (load_last),
        .OutReady    (OutReady),
        .WriteData   (WriteData),
        .WriteStrobe (WriteStrobe),
        .slot_free   (slot_free),
        .FrameDone   (FrameDone)
    );

endmodule

// File: tb/tb_config_stream_tx.sv
// Directed bench for config_stream_tx: table of frame vectors plus
// hand-written back-to-back, reset and idle sequences.
module tb_config_stream_tx;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        FrameValid;
    logic [31:0] FrameAddress;
    logic        FrameReady;
    logic        DataValid;
    logic [31:0] DataWord;
    logic        DataReady;
    logic        EndSession;
    logic [31:0] WriteData;
    logic        WriteStrobe;
    logic        OutReady;
    logic        Synced;
    logic        FrameDone;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit rand_mode = 0;

    logic [31:0] cap_w[$];
    bit          cap_d[$];
    int          cap_t[$];
    logic [31:0] exp_w[$];
    bit          exp_d[$];

    bit          stall_prev = 0;
    logic [31:0] prev_data  = '0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] exp_hdr;
        logic [31:0] base;
        bit          rand_ready;
        bit          combined;
    } vec_t;

    vec_t vecs[5];

    config_stream_tx dut (
        .CLK          (CLK),
        .Reset        (Reset),
        .FrameValid   (FrameValid),
        .FrameAddress (FrameAddress),
        .FrameReady   (FrameReady),
        .DataValid    (DataValid),
        .DataWord     (DataWord),
        .DataReady    (DataReady),
        .EndSession   (EndSession),
        .WriteData    (WriteData),
        .WriteStrobe  (WriteStrobe),
        .OutReady     (OutReady),
        .Synced       (Synced),
        .FrameDone    (FrameDone)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Transfer capture and stall-hold check, sampled mid-cycle.
    always @(negedge CLK) begin
        if (stall_prev) begin
            chk("stall_hold_data", WriteData, prev_data);
            chk("stall_hold_strobe", {31'b0, WriteStrobe}, 32'd1);
        end
        if (WriteStrobe && OutReady) begin
            cap_w.push_back(WriteData);
            cap_d.push_back(FrameDone);
            cap_t.push_back(cyc);
        end else if (FrameDone) begin
            chk("framedone_without_transfer", 32'd1, 32'd0);
        end
        stall_prev = WriteStrobe && !OutReady && !Reset;
        prev_data  = WriteData;
    end

    initial begin
        forever begin
            @(posedge CLK);
            #1;
            OutReady = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic offer_frame(input logic [31:0] addr);
        bit acc;
        acc = 0;
        FrameValid   = 1'b1;
        FrameAddress = addr;
        for (int n = 0; n < 300 && !acc; n++) begin
            @(negedge CLK);
            acc = FrameReady;
            tick();
        end
        FrameValid = 1'b0;
        chk("frame_accept", {31'b0, acc}, 32'd1);
    endtask

    task automatic send_word(input logic [31:0] w);
        bit acc;
        acc = 0;
        DataValid = 1'b1;
        DataWord  = w;
        for (int n = 0; n < 300 && !acc; n++) begin
            @(negedge CLK);
            acc = DataReady;
            tick();
        end
        DataValid = 1'b0;
        if (!acc) chk("data_accept", 32'd0, 32'd1);
    endtask

    task automatic end_session();
        bit done;
        done = 0;
        EndSession = 1'b1;
        for (int n = 0; n < 300 && !done; n++) begin
            tick();
            done = !Synced;
        end
        EndSession = 1'b0;
        chk("desync_accept", {31'b0, done}, 32'd1);
    endtask

    task automatic drain();
        bit idle;
        idle = 0;
        for (int n = 0; n < 300 && !idle; n++) begin
            @(negedge CLK);
            idle = !WriteStrobe;
        end
        tick();
        chk("drain", {31'b0, idle}, 32'd1);
    endtask

    task automatic clear_cap();
        cap_w.delete();
        cap_d.delete();
        cap_t.delete();
        exp_w.delete();
        exp_d.delete();
    endtask

    task automatic push_frame_exp(input logic [31:0] hdr, input logic [31:0] base);
        exp_w.push_back(hdr);
        exp_d.push_back(1'b0);
        for (int i = 1; i <= 16; i++) begin
            exp_w.push_back(base + 32'(i));
            exp_d.push_back(i == 16);
        end
    endtask

    task automatic check_seq(input string name);
        int n;
        chk({name, "_length"}, 32'(cap_w.size()), 32'(exp_w.size()));
        n = (cap_w.size() < exp_w.size()) ? cap_w.size() : exp_w.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_word%0d", name, i), cap_w[i], exp_w[i]);
            chk($sformatf("%s_done%0d", name, i), {31'b0, cap_d[i]}, {31'b0, exp_d[i]});
        end
    endtask

    task automatic send_frame_data(input logic [31:0] base);
        for (int i = 1; i <= 16; i++) send_word(base + 32'(i));
    endtask

    initial begin
        vecs[0] = '{addr: 32'h0000_0003, exp_hdr: 32'h0000_0003, base: 32'h0, rand_ready: 0, combined: 0};
        vecs[1] = '{addr: 32'hFFFF_FFFF, exp_hdr: 32'hFFEF_FFFF, base: 32'h100, rand_ready: 0, combined: 0};
        vecs[2] = '{addr: 32'h0010_0000, exp_hdr: 32'h0000_0000, base: 32'h200, rand_ready: 0, combined: 0};
        vecs[3] = '{addr: 32'h0000_0003, exp_hdr: 32'h0000_0003, base: 32'h0, rand_ready: 1, combined: 0};
        vecs[4] = '{addr: 32'h1234_5678, exp_hdr: 32'h1224_5678, base: 32'h300, rand_ready: 0, combined: 1};

        Reset = 1'b1; FrameValid = 1'b0; FrameAddress = '0; DataValid = 1'b0;
        DataWord = '0; EndSession = 1'b0; OutReady = 1'b1;
        repeat (3) tick();
        Reset = 1'b0;
        chk("reset_strobe", {31'b0, WriteStrobe}, 32'd0);
        chk("reset_data", WriteData, 32'd0);
        chk("reset_synced", {31'b0, Synced}, 32'd0);
        chk("reset_frameready", {31'b0, FrameReady}, 32'd0);
        chk("reset_dataready", {31'b0, DataReady}, 32'd0);
        chk("reset_framedone", {31'b0, FrameDone}, 32'd0);

        // EndSession alone in IDLE does nothing.
        EndSession = 1'b1;
        repeat (3) tick();
        EndSession = 1'b0;
        chk("idle_end_strobe", {31'b0, WriteStrobe}, 32'd0);
        chk("idle_end_synced", {31'b0, Synced}, 32'd0);
        $display("idle EndSession ignored: strobe=%b synced=%b", WriteStrobe, Synced);

        for (int v = 0; v < 5; v++) begin
            clear_cap();
            rand_mode = vecs[v].rand_ready;
            if (vecs[v].combined) EndSession = 1'b1;
            offer_frame(vecs[v].addr);
            send_frame_data(vecs[v].base);
            end_session();
            drain();
            rand_mode = 0;
            exp_w.push_back(32'hFAB0_FAB1);
            exp_d.push_back(1'b0);
            push_frame_exp(vecs[v].exp_hdr, vecs[v].base);
            exp_w.push_back(32'h0010_0000);
            exp_d.push_back(1'b0);
            check_seq($sformatf("vec%0d", v));
            if (!vecs[v].rand_ready && cap_t.size() == 19)
                chk($sformatf("vec%0d_consecutive", v), 32'(cap_t[18] - cap_t[0]), 32'd18);
            $display("vector %0d addr=%h header=%h words=%0d rand=%0b combined=%0b",
                     v, vecs[v].addr, (cap_w.size() > 1) ? cap_w[1] : 32'hx,
                     cap_w.size(), vecs[v].rand_ready, vecs[v].combined);
        end

        // Back-to-back frames share one sync word.
        clear_cap();
        offer_frame(32'h0000_0010);
        send_frame_data(32'h1000);
        offer_frame(32'h0000_0020);
        send_frame_data(32'h2000);
        end_session();
        drain();
        exp_w.push_back(32'hFAB0_FAB1);
        exp_d.push_back(1'b0);
        push_frame_exp(32'h0000_0010, 32'h1000);
        push_frame_exp(32'h0000_0020, 32'h2000);
        exp_w.push_back(32'h0010_0000);
        exp_d.push_back(1'b0);
        check_seq("b2b");
        $display("back-to-back: %0d words transferred", cap_w.size());

        // Reset in the middle of a frame.
        clear_cap();
        offer_frame(32'h0000_0005);
        for (int i = 1; i <= 5; i++) send_word(32'h500 + 32'(i));
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("midreset_strobe", {31'b0, WriteStrobe}, 32'd0);
        chk("midreset_synced", {31'b0, Synced}, 32'd0);
        clear_cap();
        offer_frame(32'h0000_0006);
        send_frame_data(32'h600);
        end_session();
        drain();
        exp_w.push_back(32'hFAB0_FAB1);
        exp_d.push_back(1'b0);
        push_frame_exp(32'h0000_0006, 32'h600);
        exp_w.push_back(32'h0010_0000);
        exp_d.push_back(1'b0);
        check_seq("after_reset");
        $display("mid-frame reset: restart first word=%h", (cap_w.size() > 0) ? cap_w[0] : 32'hx);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
